sail_mem_commit: RTL and testbench

Consumer end of the Sail memory-write path: accepts the byte-granular write records (physical address plus data byte) produced by the write-side memory primitives and commits them to the backing byte memory one byte per cycle. Records are buffered in a small FIFO and drained in order. Batch boundaries, one per instruction, are reported back. A pending-write probe lets the read side detect read-after-write hazards against writes not yet committed.

---
 rtl/sail_mem_commit_pkg.sv | 27 ++
 rtl/sail_mem_commit_if.sv | 54 +++++
 rtl/sail_commit_fifo.sv | 81 ++++++++
 rtl/sail_mem_commit.sv | 127 ++++++++++++
 tb/tb_sail_mem_commit.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sail_mem_commit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sail_mem_commit_pkg : shared types for the Sail memory-write commit path.  |
// | Optional tag fields: SAIL_MEM_COMMIT_TAG_EN        Revision: 1.0           |
// +----------------------------------------------------------------------------+
package sail_mem_commit_pkg;

    localparam int PADDR_W = 64;
    localparam int DATA_W  = 8;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [DATA_W-1:0]  data;
        logic               last;
`ifdef SAIL_MEM_COMMIT_TAG_EN
        logic               tag_we;
        logic               tag;
`endif
    } sail_write_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sail_mem_commit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sail_mem_commit_if : record input, memory write, batch and probe signals.  |
// | Optional tag signals: SAIL_MEM_COMMIT_TAG_EN       Revision: 1.0           |
// +----------------------------------------------------------------------------+
interface sail_mem_commit_if #(
    parameter int CNT_W = 32
);
    import sail_mem_commit_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PADDR_W-1:0] in_paddr;
    logic [DATA_W-1:0]  in_data;
    logic               in_last;
    logic               mem_wr_en;
    logic [PADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0]  mem_wr_data;
    logic               mem_wr_ack;
    logic               batch_done;
    logic [CNT_W-1:0]   batch_count;
    logic               busy;
    logic [PADDR_W-1:0] probe_addr;
    logic               probe_hit;
`ifdef SAIL_MEM_COMMIT_TAG_EN
    logic               in_tag_we;
    logic               in_tag;
    logic               mem_tag_we;
    logic               mem_tag;
`endif

    // slave: the commit block; master: the record producer / memory side
    modport slave (
        input  in_valid, in_paddr, in_data, in_last, mem_wr_ack, probe_addr,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        output batch_done, batch_count, busy, probe_hit
`ifdef SAIL_MEM_COMMIT_TAG_EN
        , input in_tag_we, in_tag
        , output mem_tag_we, mem_tag
`endif
    );

    modport master (
        output in_valid, in_paddr, in_data, in_last, mem_wr_ack, probe_addr,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  batch_done, batch_count, busy, probe_hit
`ifdef SAIL_MEM_COMMIT_TAG_EN
        , output in_tag_we, in_tag
        , input mem_tag_we, mem_tag
`endif
    );

endinterface
`default_nettype wire

// File: rtl/sail_commit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sail_commit_fifo : synchronous write-record FIFO exporting per-entry valid |
// | and paddr for the hazard probe.                    Revision: 1.0           |
// +----------------------------------------------------------------------------+
module sail_commit_fifo
    import sail_mem_commit_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic                             clk,
    input  wire logic                             rst_n,
    input  wire logic                             push_i,
    input  wire sail_write_t                      wdata_i,
    input  wire logic                             pop_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [AW:0]                           count_o,
    output sail_write_t                           head_o,
    output logic [DEPTH-1:0]                      valid_o,
    output logic [DEPTH-1:0][PADDR_W-1:0]         paddr_o
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    sail_write_t      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [DEPTH-1:0] valid_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == c_full_count);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;

    // No pass-through: a full FIFO refuses a push even if it pops this cycle
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q          <= rd_ptr_q + 1'b1;
                valid_q[rd_ptr_q] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            paddr_o[i] = mem_q[i].paddr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sail_mem_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sail_mem_commit : buffers byte write records and commits one per cycle.    |
// | Optional tag path: SAIL_MEM_COMMIT_TAG_EN          Revision: 1.0           |
// +----------------------------------------------------------------------------+
module sail_mem_commit
    import sail_mem_commit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sail_mem_commit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_e                       state_q;
    state_e                       state_d;
    logic                         batch_done_q;
    logic [CNT_W-1:0]             batch_count_q;

    sail_write_t                  w_wdata;
    sail_write_t                  w_head;
    logic                         w_full;
    logic                         w_empty;
    logic [AW:0]                  w_count;
    logic [DEPTH-1:0]             w_valid;
    logic [DEPTH-1:0][PADDR_W-1:0] w_paddr;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_probe_hit;

    always_comb begin
        w_wdata        = '0;
        w_wdata.paddr  = bus.in_paddr;
        w_wdata.data   = bus.in_data;
        w_wdata.last   = bus.in_last;
`ifdef SAIL_MEM_COMMIT_TAG_EN
        w_wdata.tag_we = bus.in_tag_we;
        w_wdata.tag    = bus.in_tag;
`endif
    end

    assign w_push = bus.in_valid && !w_full;
    assign w_pop  = (state_q == WRITE) && bus.mem_wr_ack;

    sail_commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.in_valid),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .head_o  (w_head),
        .valid_o (w_valid),
        .paddr_o (w_paddr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            batch_done_q  <= 1'b0;
            batch_count_q <= '0;
        end else begin
            state_q      <= state_d;
            batch_done_q <= w_pop && w_head.last;
            if (w_pop && w_head.last) begin
                batch_count_q <= batch_count_q + 1'b1;
            end
        end
    end

    // WRITE is only ever entered or kept with a non-empty FIFO, so the head is valid there
    always_comb begin
        state_d         = state_q;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
`ifdef SAIL_MEM_COMMIT_TAG_EN
        bus.mem_tag_we  = 1'b0;
        bus.mem_tag     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = w_head.paddr;
                bus.mem_wr_data = w_head.data;
`ifdef SAIL_MEM_COMMIT_TAG_EN
                bus.mem_tag_we  = w_head.tag_we;
                bus.mem_tag     = w_head.tag;
`endif
                if (bus.mem_wr_ack && (w_count == (AW+1)'(1)) && !w_push) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_paddr[i] == bus.probe_addr)) begin
                w_probe_hit = 1'b1;
            end
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.batch_done  = batch_done_q;
    assign bus.batch_count = batch_count_q;
    assign bus.busy        = !w_empty;
    assign bus.probe_hit   = w_probe_hit;

endmodule
`default_nettype wire

// File: tb/tb_sail_mem_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sail_mem_commit : directed self-checking bench for sail_mem_commit.     |
// | Tag scenario under SAIL_MEM_COMMIT_TAG_EN          Revision: 1.0           |
// +----------------------------------------------------------------------------+
module tb_sail_mem_commit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sail_mem_commit_if #(.CNT_W(32)) bus ();

    sail_mem_commit #(
        .DEPTH (16),
        .CNT_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [63:0] addr, input logic [7:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_paddr = addr;
        bus.in_data  = data;
        bus.in_last  = last;
`ifdef SAIL_MEM_COMMIT_TAG_EN
        bus.in_tag_we = 1'b0;
        bus.in_tag    = 1'b0;
`endif
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.in_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
             bus.batch_done, bus.busy, bus.probe_hit} !== {1'b1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b en=%b addr=%h data=%h done=%b busy=%b hit=%b",
                     bus.in_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
                     bus.batch_done, bus.busy, bus.probe_hit);
        end
        n_checks++;
        if (bus.batch_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", bus.batch_count);
        end
    endtask

    task automatic test_single();
        bus.mem_wr_ack = 1'b1;
        push_rec(64'h1000, 8'hAB, 1'b1);
        n_checks++;
        if ({bus.mem_wr_en, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_latency: got en=%b busy=%b expected en=0 busy=1", bus.mem_wr_en, bus.busy);
        end
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !== {1'b1, 64'h1000, 8'hAB}) begin
            n_fail++;
            $display("FAIL single_write: got en=%b addr=%h data=%h expected 1 1000 ab",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
        end
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.batch_done, bus.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL single_done: got en=%b done=%b busy=%b expected 0 1 0",
                     bus.mem_wr_en, bus.batch_done, bus.busy);
        end
        tick();
        n_checks++;
        if ({bus.batch_done, bus.batch_count} !== {1'b0, 32'd1}) begin
            n_fail++;
            $display("FAIL single_count: got done=%b count=%0d expected done=0 count=1",
                     bus.batch_done, bus.batch_count);
        end
    endtask

    task automatic test_stall();
        bus.mem_wr_ack = 1'b0;
        push_rec(64'h2000, 8'h11, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.busy} !== {1'b1, 64'h2000, 8'h11, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got en=%b addr=%h data=%h busy=%b expected 1 2000 11 1",
                         c, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.busy);
            end
            tick();
        end
        bus.mem_wr_ack = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr} !== {1'b1, 64'h2000}) begin
            n_fail++;
            $display("FAIL stall_ack_cycle: got en=%b addr=%h expected 1 2000", bus.mem_wr_en, bus.mem_wr_addr);
        end
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.busy, bus.batch_done, bus.batch_count} !== {3'b000, 32'd1}) begin
            n_fail++;
            $display("FAIL stall_pop: got en=%b busy=%b done=%b count=%0d expected 0 0 0 1",
                     bus.mem_wr_en, bus.busy, bus.batch_done, bus.batch_count);
        end
        bus.mem_wr_ack = 1'b0;
    endtask

    task automatic test_fill();
        bus.mem_wr_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready push %0d: got %b expected 1", i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_paddr = 64'h5000 + 64'(i);
            bus.in_data  = 8'h20 + 8'(i);
            bus.in_last  = (i == 15);
            tick();
        end
        n_checks++;
        if ({bus.in_ready, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL fill_full: got rdy=%b busy=%b expected rdy=0 busy=1", bus.in_ready, bus.busy);
        end
        bus.in_paddr = 64'h6000;
        bus.in_data  = 8'hEE;
        bus.in_last  = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_refused: got rdy=%b expected 0", bus.in_ready);
        end
        bus.mem_wr_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !== {1'b1, 64'h5000 + 64'(i), 8'h20 + 8'(i)}) begin
                n_fail++;
                $display("FAIL fill_drain %0d: got en=%b addr=%h data=%h expected 1 %h %h",
                         i, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, 64'h5000 + 64'(i), 8'h20 + 8'(i));
            end
            tick();
        end
        n_checks++;
        if ({bus.mem_wr_en, bus.batch_done, bus.busy, bus.batch_count} !== {3'b010, 32'd2}) begin
            n_fail++;
            $display("FAIL fill_end: got en=%b done=%b busy=%b count=%0d expected 0 1 0 2",
                     bus.mem_wr_en, bus.batch_done, bus.busy, bus.batch_count);
        end
        bus.mem_wr_ack = 1'b0;
        tick();
    endtask

    task automatic test_probe();
        bus.mem_wr_ack = 1'b0;
        push_rec(64'h3000, 8'h30, 1'b0);
        push_rec(64'h3001, 8'h31, 1'b1);
        bus.probe_addr = 64'h3001;
        #1;
        n_checks++;
        if (bus.probe_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL probe_hit_3001: got %b expected 1", bus.probe_hit);
        end
        bus.probe_addr = 64'h3002;
        #1;
        n_checks++;
        if (bus.probe_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_miss_3002: got %b expected 0", bus.probe_hit);
        end
        bus.probe_addr = 64'h3001;
        bus.mem_wr_ack = 1'b1;
        tick();
        n_checks++;
        if ({bus.probe_hit, bus.mem_wr_addr} !== {1'b1, 64'h3001}) begin
            n_fail++;
            $display("FAIL probe_head_pending: got hit=%b addr=%h expected 1 3001", bus.probe_hit, bus.mem_wr_addr);
        end
        tick();
        n_checks++;
        if ({bus.probe_hit, bus.batch_done, bus.batch_count} !== {2'b01, 32'd3}) begin
            n_fail++;
            $display("FAIL probe_committed: got hit=%b done=%b count=%0d expected 0 1 3",
                     bus.probe_hit, bus.batch_done, bus.batch_count);
        end
        bus.mem_wr_ack = 1'b0;
        bus.probe_addr = 64'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.mem_wr_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_paddr = 64'h8000 + 64'(k);
            bus.in_data  = 8'h80 + 8'(k);
            bus.in_last  = (k == 3);
            tick();
            if (k > 0) begin
                n_checks++;
                if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !== {1'b1, 64'h8000 + 64'(k - 1), 8'h80 + 8'(k - 1)}) begin
                    n_fail++;
                    $display("FAIL b2b_stream %0d: got en=%b addr=%h data=%h", k - 1,
                             bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data} !== {1'b1, 64'h8003, 8'h83}) begin
            n_fail++;
            $display("FAIL b2b_last: got en=%b addr=%h data=%h expected 1 8003 83",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data);
        end
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.batch_done, bus.batch_count} !== {2'b01, 32'd4}) begin
            n_fail++;
            $display("FAIL b2b_done: got en=%b done=%b count=%0d expected 0 1 4",
                     bus.mem_wr_en, bus.batch_done, bus.batch_count);
        end
        bus.mem_wr_ack = 1'b0;
        tick();
    endtask

`ifdef SAIL_MEM_COMMIT_TAG_EN
    task automatic test_tag();
        bus.mem_wr_ack = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_paddr   = 64'h4000;
        bus.in_data    = 8'h00;
        bus.in_last    = 1'b0;
        bus.in_tag_we  = 1'b1;
        bus.in_tag     = 1'b1;
        tick();
        bus.in_paddr   = 64'h4001;
        bus.in_last    = 1'b1;
        bus.in_tag_we  = 1'b0;
        bus.in_tag     = 1'b0;
        tick();
        bus.in_valid   = 1'b0;
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_tag_we, bus.mem_tag} !== {1'b1, 64'h4000, 2'b11}) begin
            n_fail++;
            $display("FAIL tag_first: got en=%b addr=%h tag_we=%b tag=%b expected 1 4000 1 1",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_tag_we, bus.mem_tag);
        end
        bus.mem_wr_ack = 1'b1;
        tick();
        n_checks++;
        if ({bus.mem_wr_en, bus.mem_wr_addr, bus.mem_tag_we} !== {1'b1, 64'h4001, 1'b0}) begin
            n_fail++;
            $display("FAIL tag_second: got en=%b addr=%h tag_we=%b expected 1 4001 0",
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_tag_we);
        end
        tick();
        bus.mem_wr_ack = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        bus.mem_wr_ack = 1'b0;
        push_rec(64'h7000, 8'h70, 1'b1);
        push_rec(64'h7001, 8'h71, 1'b1);
        push_rec(64'h7002, 8'h72, 1'b1);
        bus.probe_addr = 64'h7000;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
             bus.batch_done, bus.busy, bus.probe_hit} !== {1'b1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b en=%b addr=%h data=%h done=%b busy=%b hit=%b",
                     bus.in_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
                     bus.batch_done, bus.busy, bus.probe_hit);
        end
        n_checks++;
        if (bus.batch_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d expected 0", bus.batch_count);
        end
        tick();
        rst_n = 1'b1;
        bus.mem_wr_ack = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({bus.mem_wr_en, bus.batch_done, bus.busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL midreset_quiet cycle %0d: got en=%b done=%b busy=%b expected 0 0 0",
                         c, bus.mem_wr_en, bus.batch_done, bus.busy);
            end
        end
        n_checks++;
        if (bus.batch_count !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_count_after: got %0d expected 0", bus.batch_count);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_paddr   = '0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.mem_wr_ack = 1'b0;
        bus.probe_addr = '0;
`ifdef SAIL_MEM_COMMIT_TAG_EN
        bus.in_tag_we  = 1'b0;
        bus.in_tag     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single();
        test_stall();
        test_fill();
        test_probe();
        test_back_to_back();
`ifdef SAIL_MEM_COMMIT_TAG_EN
        test_tag();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
